avalon_pipelined_register_slave: RTL and testbench
==================================================

Name: avalon_pipelined_register_slave

Overview:
- Single-clock Avalon-MM pipelined-read slave.
- Acts as the responder on the master side of the team's clock-crossing bridges. It is the endpoint that consumes their read/write/byteenable stream and returns readdata/readdatavalid/endofpacket.
- Holds a bank of 32-bit registers with byte-enable writes, a programmable fixed wait-state count and a fixed read latency.
- Serves as a bring-up and verification target for the bridges' waitrequest-hold and readdatavalid paths.

Parameters:
ADDR_W, 4, word-address width; bank depth is 2**ADDR_W words.
READ_LATENCY, 2, cycles from read acceptance to readdatavalid; legal range 1..8.
WAIT_CYCLES, 1, waitrequest cycles inserted before each transfer is accepted; legal range 0..15.

Ports:
clk  input  1  sole clock; all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
address  input  ADDR_W  word address.
byteenable  input  4  byte lanes for writes; ignored for reads.
read  input  1  read request.
write  input  1  write request.
writedata  input  32  write data.
waitrequest  output  1  stall; the master holds its command while high.
readdata  output  32  read data; valid only with readdatavalid.
readdatavalid  output  1  one-cycle pulse per accepted read.
endofpacket  output  1  qualifies the final word of the bank; valid with readdatavalid.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low, on reset_n.
- Reset values:
  - All bank registers 0; readdata 0; readdatavalid 0; endofpacket 0.
  - Wait counter 0; read pipeline flushed.
  - waitrequest is combinational. It is 0 whenever read and write are both low.
- Request: req = read | write.
- Wait states:
  - waitrequest = req & (wait_cnt != WAIT_CYCLES).
  - wait_cnt increments each cycle that req is high and waitrequest is high.
  - wait_cnt clears to 0 on acceptance (req & !waitrequest), or when req is low.
  - Each transfer therefore sees exactly WAIT_CYCLES stall cycles.
  - WAIT_CYCLES=0 means waitrequest is constantly 0, so back-to-back acceptance every cycle is allowed.
- Write acceptance: at the acceptance edge, byte lane i of bank[address] is loaded from writedata[8i+7:8i] when byteenable[i]=1. Other lanes are unchanged.
- Read acceptance:
  - At the acceptance edge, bank[address] and the flag (address == 2**ADDR_W-1) enter stage 1 of a READ_LATENCY-deep shift pipeline.
  - The read sees every write accepted in earlier cycles.
- Read response timing:
  - A read accepted in cycle N produces readdatavalid=1 in cycle N+READ_LATENCY, for exactly one cycle.
  - In that cycle readdata carries the word and endofpacket carries the flag.
  - In cycles with no valid response, readdata=0 and endofpacket=0.
- Outstanding reads:
  - Up to READ_LATENCY reads may be in flight.
  - The pipeline advances every cycle and never backpressures, because readdatavalid cannot be stalled.
  - Responses come back in acceptance order with no gaps relative to the acceptance pattern.
- read and write high together: treated as a write. No read response is generated.
- Address: the full ADDR_W bits are decoded. Every address is implemented; there is no aliasing or wrap inside the bank.
- Command changes during wait states: if the command changes while waitrequest is high (a protocol violation by the master), the values present on the acceptance cycle are used.
- Reset asserted mid-operation:
  - In-flight reads are discarded; no readdatavalid follows.
  - Bank contents are cleared.
  - waitrequest drops immediately if req is low. Otherwise the wait count restarts from 0 after reset releases.
- Latency summary: write-to-readback visibility is 1 cycle after acceptance. Read latency is READ_LATENCY cycles. Per-transfer throughput is 1/(WAIT_CYCLES+1).

Test Plan:
- Reset/idle: reset_n low 3 cycles, then idle -> waitrequest=0, readdatavalid=0, readdata=0, endofpacket=0. A read of any address returns 0x00000000.
- Byte-enable write:
  - Write 0xDEADBEEF to addr 3 with byteenable=4'b1111.
  - Then write 0x11223344 to addr 3 with byteenable=4'b0101.
  - Read addr 3 -> readdata=0xDE22BE44, arriving READ_LATENCY cycles after acceptance.
- Wait states: WAIT_CYCLES=3, read held high on addr 5 -> waitrequest high for exactly 3 cycles, then low for 1. readdatavalid follows acceptance by READ_LATENCY=2 cycles.
- Pipelined burst:
  - WAIT_CYCLES=0; preload addr 0..3 with 0xA0..0xA3.
  - Issue 4 back-to-back reads of 0,1,2,3 -> 4 consecutive readdatavalid pulses with data 0xA0,0xA1,0xA2,0xA3, the first in cycle N+2.
- End of packet: read addr 15 (ADDR_W=4) -> endofpacket=1 only in the readdatavalid cycle. A read of addr 14 gives endofpacket=0.
- Reset mid-flight and simultaneous request:
  - Accept 2 reads, then assert reset_n low in the following cycle -> no readdatavalid ever appears.
  - After release, read=write=1 to addr 2 with data 0x55 -> no response. A subsequent read of addr 2 returns 0x00000055.

Source files
------------

// File: rtl/avalon_pipelined_register_slave_if.sv
// Avalon-MM pipelined-read bus between a master (bridge) and the register slave.
interface avalon_pipelined_register_slave_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              endofpacket;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid, endofpacket
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid, endofpacket
    );
endinterface

// File: rtl/avalon_pipelined_register_slave.sv
// Avalon-MM register bank slave: byte-enable writes, fixed wait states per
// transfer and a fixed-latency, non-stallable read response pipeline.
module avalon_pipelined_register_slave #(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WAIT_CYCLES  = 1
) (
    input  logic clk,
    input  logic reset_n,
    avalon_pipelined_register_slave_if.slave bus
);
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic              req;
    logic              stall;
    logic              accept;
    logic              wr_accept;
    logic              rd_accept;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] bank     [DEPTH];
    logic [DATA_W-1:0] pl_data  [READ_LATENCY];
    logic              pl_valid [READ_LATENCY];
    logic              pl_eop   [READ_LATENCY];

    // read+write together is a write; a stalled command is only sampled on acceptance
    assign req       = bus.read | bus.write;
    assign stall     = req & (wait_cnt != CNT_W'(WAIT_CYCLES));
    assign accept    = req & ~stall;
    assign wr_accept = accept & bus.write;
    assign rd_accept = accept & bus.read & ~bus.write;

    assign bus.waitrequest   = stall;
    assign bus.readdata      = pl_data[READ_LATENCY-1];
    assign bus.readdatavalid = pl_valid[READ_LATENCY-1];
    assign bus.endofpacket   = pl_eop[READ_LATENCY-1];

    // Wait-state counter, restarts for every transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!req || accept) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Register bank with per-lane write enables
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank[i] <= '0;
            end
        end else if (wr_accept) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (bus.byteenable[i]) begin
                    bank[bus.address][8*i +: 8] <= bus.writedata[8*i +: 8];
                end
            end
        end
    end

    // Read response shift pipeline; payload is zeroed in empty slots
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pl_data[i]  <= '0;
                pl_valid[i] <= 1'b0;
                pl_eop[i]   <= 1'b0;
            end
        end else begin
            pl_valid[0] <= rd_accept;
            pl_data[0]  <= rd_accept ? bank[bus.address] : '0;
            pl_eop[0]   <= rd_accept & (bus.address == LAST_ADDR);
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pl_data[i]  <= pl_data[i-1];
                pl_valid[i] <= pl_valid[i-1];
                pl_eop[i]   <= pl_eop[i-1];
            end
        end
    end
endmodule

// File: tb/tb_avalon_pipelined_register_slave.sv
// Scoreboard bench: two slaves (0 and 3 wait states) driven by a serial master,
// responses checked against a word-array model for data, endofpacket and arrival cycle.
module tb_avalon_pipelined_register_slave;
    localparam int unsigned RL = 2;
    localparam int unsigned W0 = 0;
    localparam int unsigned W1 = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        eop;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] cyc = '0;
    int errors = 0;
    int checks = 0;

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];
    exp_t q0 [$];
    exp_t q1 [$];

    avalon_pipelined_register_slave_if #(.ADDR_W(4)) bus0 ();
    avalon_pipelined_register_slave_if #(.ADDR_W(4)) bus1 ();

    avalon_pipelined_register_slave #(.ADDR_W(4), .READ_LATENCY(RL), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    avalon_pipelined_register_slave #(.ADDR_W(4), .READ_LATENCY(RL), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic wreq(input int d);
        return (d == 0) ? bus0.waitrequest : bus1.waitrequest;
    endfunction

    task automatic drive(input int d, input logic rd, input logic wr, input logic [3:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (d == 0) begin
            bus0.read = rd; bus0.write = wr; bus0.address = a; bus0.byteenable = be; bus0.writedata = wd;
        end else begin
            bus1.read = rd; bus1.write = wr; bus1.address = a; bus1.byteenable = be; bus1.writedata = wd;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Reference behaviour of one accepted transfer
    task automatic model_accept(input int d, input logic rd, input logic wr, input logic [3:0] a,
                                input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        logic [31:0] w;
        w = (d == 0) ? mem0[a] : mem1[a];
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
            if (d == 0) mem0[a] = w; else mem1[a] = w;
        end else if (rd) begin
            e.data = w;
            e.eop  = (a == 4'd15);
            e.cyc  = cyc + RL;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic xfer(input int d, input logic rd, input logic wr, input logic [3:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        int stalls = 0;
        bit done = 0;
        drive(d, rd, wr, a, be, wd);
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (wreq(d)) stalls++;
            else begin
                model_accept(d, rd, wr, a, be, wd);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: no acceptance within 40 cycles", d);
        end
        chk($sformatf("stall_cycles_dut%0d", d), 64'(stalls), (d == 0) ? 64'(W0) : 64'(W1));
    endtask

    task automatic idle(input int d, input int n);
        drive(d, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: every cycle either a queued response or an all-zero idle bus
    always @(negedge clk) begin
        exp_t e;
        if (bus0.readdatavalid) begin
            if (q0.size() == 0) chk("unexpected_rdv_dut0", 64'(1), 64'(0));
            else begin
                e = q0.pop_front();
                chk("readdata_dut0", 64'(bus0.readdata), 64'(e.data));
                chk("eop_dut0", 64'(bus0.endofpacket), 64'(e.eop));
                chk("rdv_cycle_dut0", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            chk("idle_out_dut0", {31'd0, bus0.endofpacket, bus0.readdata}, 64'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus1.readdatavalid) begin
            if (q1.size() == 0) chk("unexpected_rdv_dut1", 64'(1), 64'(0));
            else begin
                e = q1.pop_front();
                chk("readdata_dut1", 64'(bus1.readdata), 64'(e.data));
                chk("eop_dut1", 64'(bus1.endofpacket), 64'(e.eop));
                chk("rdv_cycle_dut1", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            chk("idle_out_dut1", {31'd0, bus1.endofpacket, bus1.readdata}, 64'd0);
        end
    end

    initial begin
        logic rd, wr;
        int r;
        clear_model();
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_waitrequest", {62'd0, bus0.waitrequest, bus1.waitrequest}, 64'd0);
        @(posedge clk);
        #1;

        // Reads after reset, then byte-enable merge and wait states on the 3-wait slave
        xfer(1, 1'b1, 1'b0, 4'd9, 4'hF, 32'd0);
        xfer(1, 1'b0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
        xfer(1, 1'b0, 1'b1, 4'd3, 4'h5, 32'h11223344);
        xfer(1, 1'b1, 1'b0, 4'd3, 4'h0, 32'd0);
        xfer(1, 1'b1, 1'b0, 4'd5, 4'h0, 32'd0);
        xfer(1, 1'b1, 1'b0, 4'd15, 4'h0, 32'd0);
        xfer(1, 1'b1, 1'b0, 4'd14, 4'h0, 32'd0);
        idle(1, 4);

        // Back-to-back preload and burst on the zero-wait slave
        for (int i = 0; i < 4; i++) xfer(0, 1'b0, 1'b1, 4'(i), 4'hF, 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) xfer(0, 1'b1, 1'b0, 4'(i), 4'hF, 32'd0);
        xfer(0, 1'b0, 1'b1, 4'd15, 4'hF, 32'hCAFEF00D);
        xfer(0, 1'b1, 1'b0, 4'd15, 4'h0, 32'd0);
        xfer(0, 1'b1, 1'b0, 4'd14, 4'h0, 32'd0);
        idle(0, 4);

        // Reset with two reads in flight: responses must never appear
        xfer(0, 1'b1, 1'b0, 4'd0, 4'h0, 32'd0);
        xfer(0, 1'b1, 1'b0, 4'd1, 4'h0, 32'd0);
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(0, 3);

        // Simultaneous read+write acts as a write only
        xfer(0, 1'b1, 1'b1, 4'd2, 4'hF, 32'h55);
        xfer(0, 1'b1, 1'b0, 4'd2, 4'h0, 32'd0);
        xfer(0, 1'b1, 1'b0, 4'd0, 4'h0, 32'd0);
        idle(0, 1);
        xfer(1, 1'b1, 1'b0, 4'd3, 4'h0, 32'd0);
        idle(1, 4);

        // Randomized mix of reads, writes, read+write and idle gaps
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 80; n++) begin
                r = int'($urandom_range(0, 9));
                rd = (r < 5) || (r == 9);
                wr = (r >= 5);
                xfer(d, rd, wr, 4'($urandom_range(0, 15)), 4'($urandom), $urandom);
                if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 2)));
            end
            idle(d, 1);
        end

        idle(0, RL + 4);
        chk("drain_dut0", 64'(q0.size()), 64'd0);
        chk("drain_dut1", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
